// File: rtl/prism_cfg_pkg.sv
// Shared types and sizing helpers for the PRISM serial configuration receiver.
package prism_cfg_pkg;

  // Default width of one configuration frame.
  localparam int unsigned DefCfgBits = 64;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  // Bit count must reach CFG_BITS+1 so that an over-long frame can be told apart.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 2);
  endfunction

endpackage

// File: rtl/prism_cfg_rx_if.sv
// Serial configuration link: host drives sclk/cs_n/sdi and reads sdo back.
interface prism_cfg_rx_if;

  logic cfg_sclk;
  logic cfg_cs_n;
  logic cfg_sdi;
  logic cfg_sdo;

  modport master (
    output cfg_sclk,
    output cfg_cs_n,
    output cfg_sdi,
    input  cfg_sdo
  );

  modport slave (
    input  cfg_sclk,
    input  cfg_cs_n,
    input  cfg_sdi,
    output cfg_sdo
  );

endinterface

// File: rtl/prism_sync_edge.sv
// N-stage synchroniser for an asynchronous input with rise/fall pulses.
// Edges are detected on the last stage against one extra delay flop.
module prism_sync_edge #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              dly_q;

  // Synchroniser chain plus edge-detect delay flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {Stages{RstVal}};
      dly_q  <= RstVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], din};
      dly_q  <= sync_q[Stages-1];
    end
  end

  assign dout = sync_q[Stages-1];
  assign rise = sync_q[Stages-1] & ~dly_q;
  assign fall = ~sync_q[Stages-1] & dly_q;

endmodule

// File: rtl/prism_cfg_rx.sv
// PRISM serial configuration receiver: assembles a CFG_BITS frame MSB first,
// commits it atomically to cfg_word and shifts the prior word out on sdo.
module prism_cfg_rx
  import prism_cfg_pkg::*;
#(
  parameter int unsigned CFG_BITS    = DefCfgBits,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  prism_cfg_rx_if.slave       cfg,
  output logic [CFG_BITS-1:0] cfg_word,
  output logic                cfg_valid,
  output logic                cfg_err,
  output logic                busy
);

  localparam int unsigned CntW = cnt_width(CFG_BITS);

  localparam logic [CntW-1:0] CntFull = CntW'(CFG_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(CFG_BITS + 1);

  logic sclk_sync, sclk_rise, sclk_fall_unused;
  logic cs_sync_unused, cs_rise, cs_fall;
  logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

  prism_sync_edge #(
    .Stages (SYNC_STAGES),
    .RstVal (1'b0)
  ) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (cfg.cfg_sclk),
    .dout (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  prism_sync_edge #(
    .Stages (SYNC_STAGES),
    .RstVal (1'b1)
  ) u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (cfg.cfg_cs_n),
    .dout (cs_sync_unused),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  prism_sync_edge #(
    .Stages (SYNC_STAGES),
    .RstVal (1'b0)
  ) u_sync_sdi (
    .clk  (clk),
    .rst  (rst),
    .din  (cfg.cfg_sdi),
    .dout (sdi_sync),
    .rise (sdi_rise_unused),
    .fall (sdi_fall_unused)
  );

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [CFG_BITS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                sdo_q;

  // Frame state, shift register and committed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      sdo_q   <= shreg_q[CFG_BITS-1];
    end
  end

  // Next-state: open on cs_n fall, shift on sclk rise, judge length on cs_n rise.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          // Preload the current word so the host reads it back while writing.
          shreg_d = word_q;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A coincident cs_n rise still takes this edge's bit.
        if (sclk_rise) begin
          shreg_d = {shreg_q[CFG_BITS-2:0], sdi_sync};
          if (count_q != CntSat) count_d = count_q + 1'b1;
        end
        if (cs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        if (count_q == CntFull) begin
          word_d  = shreg_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end else if (count_q != '0) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_word  = word_q;
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;
  assign busy      = (state_q == SHIFT);
  assign cfg.cfg_sdo = sdo_q;

endmodule

// File: tb/tb_prism_cfg_rx.sv
// Directed bench for prism_cfg_rx: good/short/long/empty frames, readback,
// asynchronous mid-frame reset and coincident sclk/cs_n edges.
module tb_prism_cfg_rx;

  logic        clk;
  logic        rst;
  logic [63:0] cfg_word;
  logic        cfg_valid;
  logic        cfg_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int vcount = 0;

  prism_cfg_rx_if bus ();

  prism_cfg_rx #(
    .CFG_BITS    (64),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (bus),
    .cfg_word  (cfg_word),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clocks on which cfg_valid is high.
  always @(posedge clk) if (cfg_valid === 1'b1) vcount <= vcount + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame at clk/8, MSB first; sdo captured just before each sclk rise.
  task automatic frame(input logic [127:0] data, input int nbits, input bit coincide,
                       output logic [63:0] rb);
    rb = '0;
    bus.cfg_cs_n = 1'b0;
    wait_clks(4);
    chk("busy_open", {63'd0, busy}, 64'd1);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.cfg_sdi = data[i];
      wait_clks(4);
      rb = {rb[62:0], bus.cfg_sdo};
      bus.cfg_sclk = 1'b1;
      if (coincide && i == 0) bus.cfg_cs_n = 1'b1;
      wait_clks(4);
      bus.cfg_sclk = 1'b0;
    end
    if (!coincide) begin
      wait_clks(4);
      bus.cfg_cs_n = 1'b1;
    end
    wait_clks(10);
  endtask

  logic [63:0] rb;
  int v0;

  initial begin
    rst = 1'b1;
    bus.cfg_sclk = 1'b0;
    bus.cfg_cs_n = 1'b1;
    bus.cfg_sdi  = 1'b0;
    wait_clks(3);
    chk("rst_word", cfg_word, 64'd0);
    chk("rst_valid", {63'd0, cfg_valid}, 64'd0);
    chk("rst_err", {63'd0, cfg_err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sdo", {63'd0, bus.cfg_sdo}, 64'd0);
    rst = 1'b0;
    wait_clks(4);

    // Good frame
    v0 = vcount;
    frame({64'd0, 64'hDEADBEEF_01234567}, 64, 1'b0, rb);
    chk("good_word", cfg_word, 64'hDEADBEEF_01234567);
    chk("good_valid_cnt", 64'(vcount - v0), 64'd1);
    chk("good_err", {63'd0, cfg_err}, 64'd0);
    chk("good_busy", {63'd0, busy}, 64'd0);
    chk("good_rb", rb, 64'd0);

    // Readback of prior word while writing zero
    v0 = vcount;
    frame(128'd0, 64, 1'b0, rb);
    chk("rb_data", rb, 64'hDEADBEEF_01234567);
    chk("rb_word", cfg_word, 64'd0);
    chk("rb_valid_cnt", 64'(vcount - v0), 64'd1);

    frame({64'd0, 64'h01234567_89ABCDEF}, 64, 1'b0, rb);
    chk("load_word", cfg_word, 64'h01234567_89ABCDEF);

    // Short frame: 63 ones
    v0 = vcount;
    frame({64'd0, 64'h7FFFFFFF_FFFFFFFF}, 63, 1'b0, rb);
    chk("short_err", {63'd0, cfg_err}, 64'd1);
    chk("short_valid_cnt", 64'(vcount - v0), 64'd0);
    chk("short_word", cfg_word, 64'h01234567_89ABCDEF);

    // Empty frame leaves the sticky error alone
    v0 = vcount;
    bus.cfg_cs_n = 1'b0;
    wait_clks(8);
    bus.cfg_cs_n = 1'b1;
    wait_clks(8);
    chk("empty_valid_cnt", 64'(vcount - v0), 64'd0);
    chk("empty_err", {63'd0, cfg_err}, 64'd1);
    chk("empty_word", cfg_word, 64'h01234567_89ABCDEF);

    // Good frame clears the error
    frame({64'd0, 64'hCAFEF00D_12345678}, 64, 1'b0, rb);
    chk("clr_err", {63'd0, cfg_err}, 64'd0);
    chk("clr_word", cfg_word, 64'hCAFEF00D_12345678);

    // Long frame: 65 bits
    v0 = vcount;
    frame({63'd0, 1'b1, 64'h55555555_55555555}, 65, 1'b0, rb);
    chk("long_err", {63'd0, cfg_err}, 64'd1);
    chk("long_word", cfg_word, 64'hCAFEF00D_12345678);
    chk("long_valid_cnt", 64'(vcount - v0), 64'd0);

    frame({64'd0, 64'h11112222_33334444}, 64, 1'b0, rb);
    chk("pre_rst_word", cfg_word, 64'h11112222_33334444);

    // Asynchronous reset after 30 bits
    bus.cfg_cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 30; i++) begin
      bus.cfg_sdi = i[0];
      wait_clks(4);
      bus.cfg_sclk = 1'b1;
      wait_clks(4);
      bus.cfg_sclk = 1'b0;
    end
    chk("midrst_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_word", cfg_word, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_err", {63'd0, cfg_err}, 64'd0);
    chk("midrst_valid", {63'd0, cfg_valid}, 64'd0);
    chk("midrst_sdo", {63'd0, bus.cfg_sdo}, 64'd0);
    bus.cfg_cs_n = 1'b1;
    bus.cfg_sclk = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(4);
    v0 = vcount;
    frame({64'd0, 64'hFEDCBA98_76543210}, 64, 1'b0, rb);
    chk("postrst_word", cfg_word, 64'hFEDCBA98_76543210);
    chk("postrst_rb", rb, 64'd0);
    chk("postrst_valid_cnt", 64'(vcount - v0), 64'd1);

    // 64th sclk rise coincident with cs_n rise
    v0 = vcount;
    frame({64'd0, 64'h80000000_00000001}, 64, 1'b1, rb);
    chk("coinc_word", cfg_word, 64'h80000000_00000001);
    chk("coinc_err", {63'd0, cfg_err}, 64'd0);
    chk("coinc_valid_cnt", 64'(vcount - v0), 64'd1);
    chk("coinc_rb", rb, 64'hFEDCBA98_76543210);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
